// File: rtl/corelet_ctrl.sv
// corelet_ctrl: sequences the 34-bit corelet instruction word through one tile pass
// (weight fetch, kernel load, flush, activation fetch + execute, OFIFO drain).
//
// state   | meaning
// IDLE    | waiting for start with nonzero n_vec
// W_RD    | weight SRAM reads into L0 (row reads plus one write-tail cycle)
// K_LOAD  | kernel load from L0 into the MAC array
// K_FLUSH | pipeline flush, instruction word idle
// X_RD    | activation SRAM reads into L0 (n_vec reads plus write tail)
// EXEC    | execute, OFIFO reads allowed
// DRAIN   | finish OFIFO reads, watchdog running
// DONE    | one-cycle done pulse
module corelet_ctrl #(
  parameter int row       = 8,
  parameter int col       = 8,
  parameter int cnt_bw    = 8,
  parameter int addr_bw   = 11,
  parameter int kflush    = 16,
  parameter int drain_max = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [cnt_bw-1:0]  n_vec,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic               ofifo_valid,
  output logic [33:0]        inst,
  output logic               sram_ren,
  output logic [addr_bw-1:0] sram_addr,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [cnt_bw-1:0]  rd_cnt
);

  // One shared down-counter times every fixed-length phase; size it for the longest.
  localparam int tmr_a  = (row > col) ? row : col;
  localparam int tmr_b  = (kflush > tmr_a) ? kflush : tmr_a;
  localparam int tmr_c  = ((2 ** cnt_bw) > tmr_b) ? (2 ** cnt_bw) : tmr_b;
  localparam int tmr_bw = $clog2(tmr_c + 1);
  localparam int wd_bw  = $clog2(drain_max + 1);

  typedef enum logic [2:0] {
    IDLE, W_RD, K_LOAD, K_FLUSH, X_RD, EXEC, DRAIN, DONE
  } state_t;

  state_t             state;
  logic [tmr_bw-1:0]  tmr;
  logic [wd_bw-1:0]   wdog;
  logic [cnt_bw-1:0]  n_vec_q;
  logic [addr_bw-1:0] x_base_q;
  logic               inst_kl;
  logic               inst_ex;
  logic               inst_wr;
  logic               inst_rd;
  logic               inst_acc;
  logic               rd_fire;

  // OFIFO read is combinational so a row is popped the same cycle it is offered.
  assign rd_fire = ofifo_valid && (rd_cnt < n_vec_q) &&
                   ((state == EXEC) || (state == DRAIN));

  assign inst = {inst_acc, 26'b0, rd_fire, 2'b0, inst_rd, inst_wr, inst_ex, inst_kl};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tmr       <= '0;
      wdog      <= '0;
      n_vec_q   <= '0;
      x_base_q  <= '0;
      inst_kl   <= 1'b0;
      inst_ex   <= 1'b0;
      inst_wr   <= 1'b0;
      inst_rd   <= 1'b0;
      inst_acc  <= 1'b0;
      sram_ren  <= 1'b0;
      sram_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rd_cnt    <= '0;
    end else begin
      done     <= 1'b0;
      inst_wr  <= sram_ren;
      inst_acc <= rd_fire;
      if (rd_fire) begin
        rd_cnt <= rd_cnt + cnt_bw'(1);
      end

      case (state)
        IDLE: begin
          if (start && (n_vec != '0)) begin
            state     <= W_RD;
            busy      <= 1'b1;
            n_vec_q   <= n_vec;
            x_base_q  <= x_base;
            rd_cnt    <= '0;
            err       <= 1'b0;
            tmr       <= tmr_bw'(row);
            sram_ren  <= 1'b1;
            sram_addr <= w_base;
          end
        end

        W_RD: begin
          if (tmr > tmr_bw'(1)) begin
            sram_ren  <= 1'b1;
            sram_addr <= sram_addr + addr_bw'(1);
          end else begin
            sram_ren <= 1'b0;
          end
          if (tmr == '0) begin
            state   <= K_LOAD;
            tmr     <= tmr_bw'(col - 1);
            inst_kl <= 1'b1;
            inst_rd <= 1'b1;
          end else begin
            tmr <= tmr - tmr_bw'(1);
          end
        end

        K_LOAD: begin
          if (tmr == '0) begin
            state   <= K_FLUSH;
            tmr     <= tmr_bw'(kflush - 1);
            inst_kl <= 1'b0;
            inst_rd <= 1'b0;
          end else begin
            tmr <= tmr - tmr_bw'(1);
          end
        end

        K_FLUSH: begin
          if (tmr == '0) begin
            state     <= X_RD;
            tmr       <= tmr_bw'(n_vec_q);
            sram_ren  <= 1'b1;
            sram_addr <= x_base_q;
          end else begin
            tmr <= tmr - tmr_bw'(1);
          end
        end

        X_RD: begin
          if (tmr > tmr_bw'(1)) begin
            sram_ren  <= 1'b1;
            sram_addr <= sram_addr + addr_bw'(1);
          end else begin
            sram_ren <= 1'b0;
          end
          if (tmr == '0) begin
            state   <= EXEC;
            tmr     <= tmr_bw'(n_vec_q) - tmr_bw'(1);
            inst_ex <= 1'b1;
            inst_rd <= 1'b1;
          end else begin
            tmr <= tmr - tmr_bw'(1);
          end
        end

        EXEC: begin
          if (tmr == '0) begin
            state   <= DRAIN;
            inst_ex <= 1'b0;
            inst_rd <= 1'b0;
            wdog    <= '0;
          end else begin
            tmr <= tmr - tmr_bw'(1);
          end
        end

        // Full count means the last read already happened, so its accumulate pulse is out now.
        DRAIN: begin
          if (rd_cnt == n_vec_q) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (rd_fire) begin
            wdog <= '0;
          end else if (wdog == wd_bw'(drain_max - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            wdog <= wdog + wd_bw'(1);
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Self-checking bench for corelet_ctrl: randomized passes compared cycle by cycle
// against a timeline model of the tile-pass sequence.
module tb_corelet_ctrl;

  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  n_vec;
  logic [10:0] w_base;
  logic [10:0] x_base;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        sram_ren;
  logic [10:0] sram_addr;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  rd_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  bit vld    [MAXC];
  bit exp_rd [MAXC];
  int exp_done_idx;
  bit exp_err;
  int exp_reads;

  int obs_done_idx;
  int cnt_kl;
  int cnt_ex;
  int cnt_rd6;
  int cnt_acc;
  int lag_bad;
  logic [10:0] obs_addr[$];

  corelet_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .n_vec       (n_vec),
    .w_base      (w_base),
    .x_base      (x_base),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .sram_ren    (sram_ren),
    .sram_addr   (sram_addr),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .rd_cnt      (rd_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // Timeline model: cycle 0 is the first cycle after start is accepted.
  // Reads happen from EXEC onward on offered cycles until n are taken; DRAIN ends
  // one cycle after the count is full, or after 64 read-less DRAIN cycles.
  task automatic build_model(input int n);
    int e, d0, reads, gap;
    e = 34 + n;
    d0 = e + n;
    reads = 0;
    gap = 0;
    exp_done_idx = MAXC - 2;
    exp_err = 1'b0;
    for (int k = 0; k < MAXC; k++) exp_rd[k] = 1'b0;
    for (int k = 0; k < MAXC - 2; k++) begin
      if (k >= d0 && reads == n) begin
        exp_done_idx = k + 1;
        break;
      end
      if (k >= e && vld[k] && reads < n) begin
        exp_rd[k] = 1'b1;
        reads++;
        gap = 0;
      end else if (k >= d0) begin
        gap++;
        if (gap == 64) begin
          exp_done_idx = k + 1;
          exp_err = 1'b1;
          break;
        end
      end
    end
    exp_reads = reads;
  endtask

  // vmode: 0 = ofifo_valid low, 1 = high, 2 = random; inj = cycle for a stray start (-1 none)
  task automatic run_pass(input int n, input logic [10:0] wb, input logic [10:0] xb,
                          input int vmode, input int inj);
    int e;
    logic [33:0] ei;
    logic er;
    logic [10:0] ea;
    logic prev6;
    for (int k = 0; k < MAXC; k++)
      vld[k] = (vmode == 0) ? 1'b0 : (vmode == 1) ? 1'b1 : ($urandom_range(3, 0) != 0);
    build_model(n);
    e = 34 + n;
    obs_addr.delete();
    obs_done_idx = -1;
    cnt_kl = 0; cnt_ex = 0; cnt_rd6 = 0; cnt_acc = 0; lag_bad = 0;
    prev6 = 1'b0;

    @(negedge clk);
    start = 1'b1;
    n_vec = 8'(n);
    w_base = wb;
    x_base = xb;
    ofifo_valid = 1'b0;
    for (int k = 0; k <= exp_done_idx + 1; k++) begin
      @(negedge clk);
      start = (k == inj);
      n_vec = 8'($urandom_range(255, 1));
      w_base = 11'($urandom);
      x_base = 11'($urandom);
      ofifo_valid = vld[k];
      #1;
      er = (k < 8) || (k >= 33 && k < 33 + n);
      ea = (k < 8) ? wb + 11'(k) : xb + 11'(k - 33);
      ei = '0;
      if (k < exp_done_idx) begin
        ei[0] = (k >= 9 && k < 17);
        ei[1] = (k >= e && k < e + n);
        ei[3] = ei[0] | ei[1];
        ei[2] = (k >= 1 && k <= 8) || (k >= 34 && k <= 33 + n);
        ei[6] = exp_rd[k];
        if (k > 0) ei[33] = exp_rd[k-1];
      end

      n_cmp++;
      if (inst !== ei) begin
        n_bad++;
        $display("FAIL inst cyc=%0d n=%0d got=%h exp=%h", k, n, inst, ei);
      end
      n_cmp++;
      if (sram_ren !== er) begin
        n_bad++;
        $display("FAIL sram_ren cyc=%0d got=%b exp=%b", k, sram_ren, er);
      end
      if (er) begin
        n_cmp++;
        if (sram_addr !== ea) begin
          n_bad++;
          $display("FAIL sram_addr cyc=%0d got=%0d exp=%0d", k, sram_addr, ea);
        end
      end
      n_cmp++;
      if (busy !== (k <= exp_done_idx)) begin
        n_bad++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", k, busy, (k <= exp_done_idx));
      end
      n_cmp++;
      if (done !== (k == exp_done_idx)) begin
        n_bad++;
        $display("FAIL done cyc=%0d got=%b exp=%b", k, done, (k == exp_done_idx));
      end
      n_cmp++;
      if (err !== ((k >= exp_done_idx) ? exp_err : 1'b0)) begin
        n_bad++;
        $display("FAIL err cyc=%0d got=%b exp=%b", k, err, ((k >= exp_done_idx) ? exp_err : 1'b0));
      end
      if (k == exp_done_idx) begin
        n_cmp++;
        if (rd_cnt !== 8'(exp_reads)) begin
          n_bad++;
          $display("FAIL rd_cnt_at_done got=%0d exp=%0d", rd_cnt, exp_reads);
        end
      end

      if (sram_ren) obs_addr.push_back(sram_addr);
      cnt_kl  += int'(inst[0]);
      cnt_ex  += int'(inst[1]);
      cnt_rd6 += int'(inst[6]);
      cnt_acc += int'(inst[33]);
      if (inst[33] && !prev6) lag_bad++;
      prev6 = inst[6];
      if (done && obs_done_idx < 0) obs_done_idx = k;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    n_vec = '0;
    w_base = '0;
    x_base = '0;
    ofifo_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (inst !== 34'd0) begin n_bad++; $display("FAIL reset_inst got=%h exp=0", inst); end
    n_cmp++;
    if ({sram_ren, busy, done, err} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_flags got=%b exp=0000", {sram_ren, busy, done, err});
    end
    n_cmp++;
    if (sram_addr !== 11'd0 || rd_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_counts got addr=%0d rd_cnt=%0d exp=0", sram_addr, rd_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    ofifo_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [10:0] ex_addr[$];
    for (int i = 0; i < 8; i++) ex_addr.push_back(11'(i));
    for (int i = 0; i < 4; i++) ex_addr.push_back(11'(16 + i));
    run_pass(4, 11'd0, 11'd16, 1, -1);
    n_cmp++;
    if (obs_addr.size() !== ex_addr.size()) begin
      n_bad++;
      $display("FAIL basic_addr_len got=%0d exp=%0d", obs_addr.size(), ex_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < ex_addr.size(); i++) begin
      n_cmp++;
      if (obs_addr[i] !== ex_addr[i]) begin
        n_bad++;
        $display("FAIL basic_addr[%0d] got=%0d exp=%0d", i, obs_addr[i], ex_addr[i]);
      end
    end
    n_cmp++;
    if (cnt_kl != 8) begin n_bad++; $display("FAIL basic_kload_cycles got=%0d exp=8", cnt_kl); end
    n_cmp++;
    if (cnt_ex != 4) begin n_bad++; $display("FAIL basic_exec_cycles got=%0d exp=4", cnt_ex); end
    n_cmp++;
    if (cnt_acc != 4 || cnt_rd6 != 4) begin
      n_bad++;
      $display("FAIL basic_reads got rd=%0d acc=%0d exp=4/4", cnt_rd6, cnt_acc);
    end
    n_cmp++;
    if (lag_bad != 0) begin n_bad++; $display("FAIL basic_acc_lag got=%0d bad exp=0", lag_bad); end
    n_cmp++;
    if (obs_done_idx + 1 != 9 + 8 + 16 + 5 + 4 + 1 + 1) begin
      n_bad++;
      $display("FAIL basic_total_cycles got=%0d exp=%0d", obs_done_idx + 1, 44);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 5; p++) begin
      run_pass($urandom_range(40, 1), 11'($urandom), 11'($urandom), 2, -1);
      n_cmp++;
      if (cnt_acc != cnt_rd6 || lag_bad != 0) begin
        n_bad++;
        $display("FAIL random_acc_pairing got rd=%0d acc=%0d lagbad=%0d", cnt_rd6, cnt_acc, lag_bad);
      end
    end
  endtask

  task automatic test_watchdog();
    run_pass(4, 11'($urandom), 11'($urandom), 0, -1);
    n_cmp++;
    if (obs_done_idx - (34 + 4 + 4) != 64) begin
      n_bad++;
      $display("FAIL wdog_drain_cycles got=%0d exp=64", obs_done_idx - 42);
    end
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL wdog_err_sticky got=%b exp=1", err); end
    run_pass(3, 11'($urandom), 11'($urandom), 1, -1);
  endtask

  task automatic test_nvec_zero();
    @(negedge clk);
    start = 1'b1;
    n_vec = 8'd0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if (busy !== 1'b0 || sram_ren !== 1'b0) begin
        n_bad++;
        $display("FAIL nvec_zero cyc=%0d got busy=%b ren=%b exp=0/0", k, busy, sram_ren);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_while_busy();
    run_pass(5, 11'd100, 11'd300, 1, 34 + 5 + 1);
    n_cmp++;
    if (cnt_ex != 5) begin n_bad++; $display("FAIL busy_start_exec got=%0d exp=5", cnt_ex); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    n_vec = 8'd6;
    w_base = 11'd10;
    x_base = 11'd500;
    ofifo_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (35) @(negedge clk);
    #1;
    n_cmp++;
    if (sram_ren !== 1'b1 || sram_addr !== 11'd502) begin
      n_bad++;
      $display("FAIL rstmid_pre got ren=%b addr=%0d exp=1/502", sram_ren, sram_addr);
    end
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (inst !== 34'd0 || sram_ren !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_outputs got inst=%h ren=%b exp=0/0", inst, sram_ren);
    end
    n_cmp++;
    if (busy !== 1'b0 || sram_addr !== 11'd0) begin
      n_bad++;
      $display("FAIL rstmid_state got busy=%b addr=%0d exp=0/0", busy, sram_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    run_pass(6, 11'($urandom), 11'($urandom), 2, -1);
  endtask

  task automatic test_wrap();
    run_pass(3, 11'd2046, 11'd2047, 1, -1);
    n_cmp++;
    if (obs_addr.size() != 11) begin
      n_bad++;
      $display("FAIL wrap_len got=%0d exp=11", obs_addr.size());
    end
    for (int i = 0; i < 8 && i < obs_addr.size(); i++) begin
      n_cmp++;
      if (obs_addr[i] !== 11'((2046 + i) % 2048)) begin
        n_bad++;
        $display("FAIL wrap_addr[%0d] got=%0d exp=%0d", i, obs_addr[i], (2046 + i) % 2048);
      end
    end
  endtask

  task automatic test_max();
    run_pass(255, 11'($urandom), 11'($urandom), 2, -1);
    n_cmp++;
    if (cnt_rd6 != 255 || cnt_acc != 255) begin
      n_bad++;
      $display("FAIL max_reads got rd=%0d acc=%0d exp=255/255", cnt_rd6, cnt_acc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_watchdog();
    test_nvec_zero();
    test_start_while_busy();
    test_reset_mid();
    test_wrap();
    test_max();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
